// File: rtl/top_pkg.sv
// Shared constants and select/op encodings for the
// 18-bit accumulator processor datapath.
package top_pkg;

   localparam int DATA_W = 18;
   localparam int INS_W  = 9;

   typedef enum logic [3:0] {
      ALU_HOLD  = 4'b0000,
      ALU_A     = 4'b0001,
      ALU_B     = 4'b0010,
      ALU_ADD   = 4'b0011,
      ALU_SUB   = 4'b0100,
      ALU_AND   = 4'b0101,
      ALU_OR    = 4'b0110,
      ALU_XOR   = 4'b0111,
      ALU_NOT   = 4'b1000,
      ALU_SHL   = 4'b1001,
      ALU_SHR   = 4'b1010,
      ALU_INC   = 4'b1011,
      ALU_DEC   = 4'b1100,
      ALU_AADD  = 4'b1101,
      ALU_ZERO  = 4'b1110,
      ALU_HOLD2 = 4'b1111
   } alu_op_e;

   typedef enum logic [3:0] {
      MA_AC  = 4'd0,
      MA_TR  = 4'd1,
      MA_MDR = 4'd2,
      MA_PC  = 4'd3,
      MA_IR  = 4'd4,
      MA_IDR = 4'd5,
      MA_MAR = 4'd6
   } mux_a_e;

   typedef enum logic [1:0] {
      MB_AC   = 2'd0,
      MB_ZERO = 2'd1,
      MB_TR   = 2'd2,
      MB_MDR  = 2'd3
   } mux_b_e;

endpackage

// File: rtl/top_alu.sv
// Combinational ALU of the accumulator datapath.
// Hold codes produce 0 here; the caller keeps its register.
module top_alu
   import top_pkg::*;
#(
   parameter int W = top_pkg::DATA_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [3:0]   sel,
   output logic [W-1:0] result
);

   // Operation decode, all arithmetic wraps at W bits
   always_comb begin
      result = '0;
      case (sel)
         ALU_A:    result = a;
         ALU_B:    result = b;
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NOT:  result = ~a;
         ALU_SHL:  result = {a[W-2:0], 1'b0};
         ALU_SHR:  result = {1'b0, a[W-1:1]};
         ALU_INC:  result = a + W'(1);
         ALU_DEC:  result = a - W'(1);
         ALU_AADD: result = a + b;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/top.sv
// Accumulator processor datapath: registers, operand muxes,
// instruction ROM, data RAM and registered ALU result.
module top #(
   parameter int    DATA_W    = top_pkg::DATA_W,
   parameter int    INS_W     = top_pkg::INS_W,
   parameter string IRAM_INIT = "",
   parameter string DRAM_INIT = ""
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_pc,
   input  logic              write_pc,
   input  logic              write_iar,
   input  logic              inc_iar,
   input  logic              write_idr,
   input  logic              write_ir,
   input  logic              write_tr,
   input  logic              write_mar,
   input  logic              write_dram,
   input  logic              off_dram,
   input  logic              write1_mdr,
   input  logic              write2_mdr,
   input  logic [3:0]        select_mux_a,
   input  logic [1:0]        select_mux_b,
   input  logic [3:0]        alu_sel,
   input  logic              write_ac,
   output logic              lsb,
   output logic              neg,
   output logic [INS_W-1:0]  dout_ir,
   output logic [DATA_W-1:0] dout_ac
);

   import top_pkg::*;

   localparam int DEPTH = 1 << INS_W;

   logic [INS_W-1:0]  iram [0:DEPTH-1];
   logic [DATA_W-1:0] dram [0:DEPTH-1];

   logic [INS_W-1:0]  pc_q, pc_d, iar_q, iar_d;
   logic [INS_W-1:0]  idr_q, idr_d, ir_q, ir_d;
   logic [INS_W-1:0]  tr_q, tr_d, mar_q, mar_d;
   logic [DATA_W-1:0] mdr_q, mdr_d, ac_q, ac_d;
   logic [DATA_W-1:0] alu_r_q, alu_r_d;
   logic [DATA_W-1:0] bus_a, bus_b, alu_res;
   logic              dram_we;

   // Operand A bus, narrow sources zero-extended
   always_comb begin
      bus_a = '0;
      case (select_mux_a)
         MA_AC:   bus_a = ac_q;
         MA_TR:   bus_a = DATA_W'(tr_q);
         MA_MDR:  bus_a = mdr_q;
         MA_PC:   bus_a = DATA_W'(pc_q);
         MA_IR:   bus_a = DATA_W'(ir_q);
         MA_IDR:  bus_a = DATA_W'(idr_q);
         MA_MAR:  bus_a = DATA_W'(mar_q);
         default: bus_a = '0;
      endcase
   end

   // Operand B bus
   always_comb begin
      bus_b = '0;
      case (select_mux_b)
         MB_AC:   bus_b = ac_q;
         MB_ZERO: bus_b = '0;
         MB_TR:   bus_b = DATA_W'(tr_q);
         MB_MDR:  bus_b = mdr_q;
         default: bus_b = '0;
      endcase
   end

   top_alu #(.W(DATA_W)) u_alu (
      .a      (bus_a),
      .b      (bus_b),
      .sel    (alu_sel),
      .result (alu_res)
   );

   assign dram_we = write_dram & ~off_dram;

   // Next register values; every source is the pre-edge value
   always_comb begin
      pc_d = pc_q;
      if (write_pc)    pc_d = alu_r_q[INS_W-1:0];
      else if (inc_pc) pc_d = pc_q + INS_W'(1);

      iar_d = iar_q;
      if (write_iar)    iar_d = pc_q;
      else if (inc_iar) iar_d = iar_q + INS_W'(1);

      idr_d = write_idr ? iram[iar_q] : idr_q;
      ir_d  = write_ir  ? idr_q : ir_q;
      tr_d  = write_tr  ? idr_q : tr_q;
      mar_d = write_mar ? alu_r_q[INS_W-1:0] : mar_q;
      ac_d  = write_ac  ? alu_r_q : ac_q;

      mdr_d = mdr_q;
      if (write1_mdr && !off_dram) mdr_d = dram[mar_q];
      else if (write2_mdr)         mdr_d = alu_r_q;

      alu_r_d = alu_r_q;
      if (alu_sel != ALU_HOLD && alu_sel != ALU_HOLD2)
         alu_r_d = alu_res;
   end

   // Datapath registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= '0;
         iar_q   <= '0;
         idr_q   <= '0;
         ir_q    <= '0;
         tr_q    <= '0;
         mar_q   <= '0;
         mdr_q   <= '0;
         ac_q    <= '0;
         alu_r_q <= '0;
      end else begin
         pc_q    <= pc_d;
         iar_q   <= iar_d;
         idr_q   <= idr_d;
         ir_q    <= ir_d;
         tr_q    <= tr_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         ac_q    <= ac_d;
         alu_r_q <= alu_r_d;
      end
   end

   // Data RAM write port, suppressed while reset is high
   always_ff @(posedge clk or posedge rst) begin
      if (!rst && dram_we) dram[mar_q] <= mdr_q;
   end

   assign lsb     = ac_q[0];
   assign neg     = ac_q[DATA_W-1];
   assign dout_ir = ir_q;
   assign dout_ac = ac_q;

endmodule

// File: tb/tb_top.sv
// Bench for the accumulator datapath: directed sequences,
// an ALU vector table and random strobes against a model.
module tb_top;

   logic clk = 1'b0;
   logic rst;
   logic inc_pc, write_pc, write_iar, inc_iar, write_idr;
   logic write_ir, write_tr, write_mar, write_dram, off_dram;
   logic write1_mdr, write2_mdr, write_ac;
   logic [3:0] select_mux_a;
   logic [1:0] select_mux_b;
   logic [3:0] alu_sel;
   logic lsb, neg;
   logic [8:0] dout_ir;
   logic [17:0] dout_ac;

   top dut (
      .clk(clk), .rst(rst),
      .inc_pc(inc_pc), .write_pc(write_pc),
      .write_iar(write_iar), .inc_iar(inc_iar),
      .write_idr(write_idr), .write_ir(write_ir),
      .write_tr(write_tr), .write_mar(write_mar),
      .write_dram(write_dram), .off_dram(off_dram),
      .write1_mdr(write1_mdr), .write2_mdr(write2_mdr),
      .select_mux_a(select_mux_a), .select_mux_b(select_mux_b),
      .alu_sel(alu_sel), .write_ac(write_ac),
      .lsb(lsb), .neg(neg),
      .dout_ir(dout_ir), .dout_ac(dout_ac)
   );

   always #5 clk = ~clk;

   localparam int INC_PC = 1 << 0;
   localparam int WR_PC = 1 << 1;
   localparam int WR_IAR = 1 << 2;
   localparam int INC_IAR = 1 << 3;
   localparam int WR_IDR = 1 << 4;
   localparam int WR_IR = 1 << 5;
   localparam int WR_TR = 1 << 6;
   localparam int WR_MAR = 1 << 7;
   localparam int WR_DRAM = 1 << 8;
   localparam int OFF_DRAM = 1 << 9;
   localparam int WR1_MDR = 1 << 10;
   localparam int WR2_MDR = 1 << 11;
   localparam int WR_AC = 1 << 12;
   localparam int M = 'h3FFFF;

   typedef struct packed {
      logic [12:0] f;
      logic [3:0]  sa;
      logic [1:0]  sb;
      logic [3:0]  op;
   } strb_t;

   typedef struct {
      int op;
      int exp;
   } vec_t;

   int checks = 0;
   int errs = 0;

   int m_pc, m_iar, m_idr, m_ir, m_tr, m_mar, m_mdr, m_ac, m_alur;
   int m_iram[512];
   int m_dram[512];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   function automatic int ref_alu(input int op, input int a, input int b);
      case (op)
         1: return a;
         2: return b;
         3, 13: return (a + b) & M;
         4: return (a - b) & M;
         5: return a & b;
         6: return a | b;
         7: return a ^ b;
         8: return (~a) & M;
         9: return (a * 2) & M;
         10: return a / 2;
         11: return (a + 1) & M;
         12: return (a - 1) & M;
         default: return 0;
      endcase
   endfunction

   task automatic m_reset();
      m_pc = 0; m_iar = 0; m_idr = 0; m_ir = 0; m_tr = 0;
      m_mar = 0; m_mdr = 0; m_ac = 0; m_alur = 0;
   endtask

   task automatic m_step(input strb_t s);
      int srca[7];
      int srcb[4];
      int a, b, n_mdr, n_alur;
      srca = '{m_ac, m_tr, m_mdr, m_pc, m_ir, m_idr, m_mar};
      srcb = '{m_ac, 0, m_tr, m_mdr};
      a = (s.sa < 7) ? srca[s.sa] : 0;
      b = srcb[s.sb];
      if (s.op == 0 || s.op == 15) n_alur = m_alur;
      else n_alur = ref_alu(int'(s.op), a, b);
      n_mdr = m_mdr;
      if (s.f[10] && !s.f[9]) n_mdr = m_dram[m_mar];
      else if (s.f[11]) n_mdr = m_alur;
      if (s.f[8] && !s.f[9]) m_dram[m_mar] = m_mdr;
      if (s.f[12]) m_ac = m_alur;
      if (s.f[5]) m_ir = m_idr;
      if (s.f[6]) m_tr = m_idr;
      if (s.f[4]) m_idr = m_iram[m_iar];
      if (s.f[2]) m_iar = m_pc;
      else if (s.f[3]) m_iar = (m_iar + 1) % 512;
      if (s.f[1]) m_pc = m_alur % 512;
      else if (s.f[0]) m_pc = (m_pc + 1) % 512;
      if (s.f[7]) m_mar = m_alur % 512;
      m_mdr = n_mdr;
      m_alur = n_alur;
   endtask

   task automatic cyc(input int f, input int sa = 0,
                      input int sb = 0, input int op = 0);
      strb_t s;
      s.f = f[12:0];
      s.sa = sa[3:0];
      s.sb = sb[1:0];
      s.op = op[3:0];
      inc_pc = s.f[0]; write_pc = s.f[1];
      write_iar = s.f[2]; inc_iar = s.f[3];
      write_idr = s.f[4]; write_ir = s.f[5];
      write_tr = s.f[6]; write_mar = s.f[7];
      write_dram = s.f[8]; off_dram = s.f[9];
      write1_mdr = s.f[10]; write2_mdr = s.f[11];
      write_ac = s.f[12];
      select_mux_a = s.sa; select_mux_b = s.sb;
      alu_sel = s.op;
      @(posedge clk);
      m_step(s);
      #1;
   endtask

   task automatic set_ac(input int v);
      cyc(0, 7, 0, 14);
      cyc(WR_AC);
      for (int i = 17; i >= 0; i--) begin
         cyc(0, 0, 0, 9);
         cyc(WR_AC);
         if (((v >> i) & 1) == 1) begin
            cyc(0, 0, 0, 11);
            cyc(WR_AC);
         end
      end
   endtask

   task automatic set_mdr(input int v);
      set_ac(v);
      cyc(0, 0, 0, 1);
      cyc(WR2_MDR);
   endtask

   task automatic set_mar(input int v);
      set_ac(v);
      cyc(0, 0, 0, 1);
      cyc(WR_MAR);
   endtask

   task automatic rd_dram();
      cyc(WR1_MDR);
      cyc(0, 2, 0, 1);
      cyc(WR_AC);
   endtask

   task automatic hold_test(input int op, input string nm);
      cyc(0, 7, 0, 8);
      cyc(WR_AC);
      cyc(0, 1, 0, 1);
      cyc(WR_AC, 0, 0, op);
      cyc(WR_AC, 0, 0, op);
      chk(nm, dout_ac, 1);
   endtask

   vec_t tbl[14];

   initial begin
      tbl = '{
         '{1, 'h3FFFF}, '{2, 'h00001}, '{3, 'h00000},
         '{4, 'h3FFFE}, '{5, 'h00001}, '{6, 'h3FFFF},
         '{7, 'h3FFFE}, '{8, 'h00000}, '{9, 'h3FFFE},
         '{10, 'h1FFFF}, '{11, 'h00000}, '{12, 'h3FFFE},
         '{13, 'h00000}, '{14, 'h00000}
      };

      rst = 1'b1;
      {inc_pc, write_pc, write_iar, inc_iar, write_idr} = '0;
      {write_ir, write_tr, write_mar, write_dram, off_dram} = '0;
      {write1_mdr, write2_mdr, write_ac} = '0;
      select_mux_a = '0; select_mux_b = '0; alu_sel = '0;

      for (int i = 0; i < 512; i++) begin
         int v;
         v = $urandom_range(0, 511);
         case (i)
            0: v = 'h005;
            1: v = 'h020;
            2: v = 'h001;
            9: v = 'h1A5;
            10: v = 'h0C3;
            511: v = 'h13C;
            default: ;
         endcase
         dut.iram[i] = v[8:0];
         m_iram[i] = v;
         m_dram[i] = 0;
      end
      m_reset();

      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_ac", dout_ac, 0);
      chk("reset_ir", dout_ir, 0);
      chk("reset_lsb", lsb, 0);
      chk("reset_neg", neg, 0);
      rst = 1'b0;

      // clear the data RAM through the datapath
      for (int i = 0; i < 512; i++) begin
         cyc(WR_DRAM, 6, 0, 11);
         cyc(WR_MAR);
      end

      set_mar(32);
      set_mdr('h20001);
      cyc(WR_DRAM);

      // fetch
      cyc(WR_IAR);
      cyc(INC_PC | WR_IDR);
      cyc(WR_IR);
      chk("fetch_ir", dout_ir, 'h005);
      cyc(0, 3, 0, 1);
      cyc(WR_AC);
      chk("fetch_pc", dout_ac, 1);

      // LDAC
      cyc(INC_IAR);
      cyc(WR_IDR);
      cyc(WR_TR);
      cyc(0, 1, 1, 13);
      cyc(WR_MAR);
      cyc(WR1_MDR);
      cyc(0, 2, 0, 1);
      cyc(WR_AC);
      chk("ldac_ac", dout_ac, 'h20001);
      chk("ldac_lsb", lsb, 1);
      chk("ldac_neg", neg, 1);

      // asynchronous reset mid-run
      #2;
      rst = 1'b1;
      m_reset();
      #1;
      chk("arst_ac", dout_ac, 0);
      chk("arst_ir", dout_ir, 0);
      chk("arst_lsb", lsb, 0);
      chk("arst_neg", neg, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // store and disabled store
      set_mar(3);
      set_ac(7);
      cyc(0, 0, 0, 1);
      cyc(WR2_MDR);
      cyc(WR_DRAM);
      rd_dram();
      chk("store", dout_ac, 7);
      set_mdr(9);
      cyc(WR_DRAM | OFF_DRAM);
      rd_dram();
      chk("store_off", dout_ac, 7);

      // simultaneous RAM write and MDR load swap
      set_mdr('h155);
      cyc(WR_DRAM | WR1_MDR);
      cyc(0, 2, 0, 1);
      cyc(WR_AC);
      chk("swap_mdr", dout_ac, 7);
      rd_dram();
      chk("swap_ram", dout_ac, 'h155);

      // no RAM write while reset is high
      set_mar(0);
      set_mdr('h2AAAA);
      cyc(WR_DRAM);
      #2;
      rst = 1'b1;
      write_dram = 1'b1;
      m_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      write_dram = 1'b0;
      rd_dram();
      chk("rst_nowrite", dout_ac, 'h2AAAA);

      // ALU sweep with A=AC=3FFFF, B=TR=1
      cyc(INC_IAR);
      cyc(INC_IAR);
      cyc(WR_IDR);
      cyc(WR_TR);
      for (int i = 0; i < 14; i++) begin
         cyc(0, 7, 0, 8);
         cyc(WR_AC);
         cyc(0, 0, 2, tbl[i].op);
         cyc(WR_AC);
         chk($sformatf("alu_op%0d", tbl[i].op), dout_ac, tbl[i].exp);
      end
      hold_test(0, "hold_op0");
      hold_test(15, "hold_op15");

      // strobe priorities and wrap
      set_ac(9);
      cyc(0, 0, 0, 1);
      cyc(WR_PC | INC_PC);
      cyc(0, 3, 0, 1);
      cyc(WR_AC);
      chk("pc_prio", dout_ac, 9);
      cyc(WR_IAR | INC_IAR);
      cyc(WR_IDR);
      cyc(WR_IR);
      chk("iar_prio", dout_ir, 'h1A5);
      cyc(0, 7, 0, 8);
      cyc(WR_PC);
      cyc(WR_IAR);
      cyc(INC_PC | INC_IAR);
      cyc(WR_IDR);
      cyc(WR_IR);
      chk("iar_wrap", dout_ir, 'h005);
      cyc(0, 3, 0, 1);
      cyc(WR_AC);
      chk("pc_wrap", dout_ac, 0);

      // random strobes against the model
      for (int n = 0; n < 3000; n++) begin
         cyc($urandom_range(0, 8191), $urandom_range(0, 15),
             $urandom_range(0, 3), $urandom_range(0, 15));
         chk("rnd_ac", dout_ac, m_ac);
         chk("rnd_ir", dout_ir, m_ir);
         chk("rnd_lsb", lsb, m_ac & 1);
         chk("rnd_neg", neg, (m_ac >> 17) & 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end

endmodule
